// File: rtl/cmp_seq_if.sv
// cmp_seq_if: request/result and comparator-slice signals of cmp_seq_ctrl
interface cmp_seq_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic AequalsB;
  logic AgreaterB;
  logic AlessB;
  logic [1:0] slice_A;
  logic [1:0] slice_B;
  logic slice_eq;
  logic slice_gt;
  logic slice_lt;
  modport master (
    output start, A, B, slice_eq, slice_gt, slice_lt,
    input busy, done, AequalsB, AgreaterB, AlessB, slice_A, slice_B
  );
  modport slave (
    input start, A, B, slice_eq, slice_gt, slice_lt,
    output busy, done, AequalsB, AgreaterB, AlessB, slice_A, slice_B
  );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: MSB-first 2-bit digit compare sequencer; `define CMP_SEQ_SIGNED_EN for two's complement operands
module cmp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  cmp_seq_if.slave bus
);
  localparam int D = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0] idx;
  logic busy, done, eq_f, gt_f, lt_f;
  logic [1:0] msk, dig_a, dig_b;
  logic last;
`ifdef CMP_SEQ_SIGNED_EN
  assign msk = (idx == IW'(D - 1)) ? 2'b10 : 2'b00;
`else
  assign msk = 2'b00;
`endif
  assign last = (idx == '0);
  // current digit pair, sign-adjusted on the top digit when signed mode is built
  always_comb begin
    dig_a = a_reg[{idx, 1'b0} +: 2] ^ msk;
    dig_b = b_reg[{idx, 1'b0} +: 2] ^ msk;
  end
  assign bus.slice_A = (state == COMPARE) ? dig_a : 2'b00;
  assign bus.slice_B = (state == COMPARE) ? dig_b : 2'b00;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.AequalsB = eq_f;
  assign bus.AgreaterB = gt_f;
  assign bus.AlessB = lt_f;
  // sequencer: accept in IDLE/DONE, walk digits until first difference or LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      eq_f <= 1'b0;
      gt_f <= 1'b0;
      lt_f <= 1'b0;
      idx <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        COMPARE: begin
          if (bus.slice_gt || bus.slice_lt || last) begin
            gt_f <= bus.slice_gt;
            lt_f <= !bus.slice_gt && bus.slice_lt;
            eq_f <= !bus.slice_gt && !bus.slice_lt;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            idx <= IW'(D - 1);
            eq_f <= 1'b0;
            gt_f <= 1'b0;
            lt_f <= 1'b0;
            busy <= 1'b1;
            state <= COMPARE;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: directed checks of cmp_seq_ctrl with a behavioural 2-bit comparator
module tb_cmp_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  cmp_seq_if #(.WIDTH(8)) bus ();
  cmp_seq_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.slice_eq = (bus.slice_A == bus.slice_B);
  assign bus.slice_gt = (bus.slice_A > bus.slice_B);
  assign bus.slice_lt = (bus.slice_A < bus.slice_B);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] flags();
    return {5'b0, bus.AequalsB, bus.AgreaterB, bus.AlessB};
  endfunction
  task automatic go(input logic [7:0] a, input logic [7:0] b);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    tick();
    tick();
    chk("rst_busy", {7'b0, bus.busy}, 8'd0);
    chk("rst_done", {7'b0, bus.done}, 8'd0);
    chk("rst_flags", flags(), 8'd0);
    chk("rst_slice", {6'b0, bus.slice_A}, 8'd0);
    rst = 1'b0;
    tick();
    // test 1: C3 vs 43, first digit decides
    go(8'hC3, 8'h43);
    chk("t1_sa", {6'b0, bus.slice_A}, 8'd3);
    chk("t1_sb", {6'b0, bus.slice_B}, 8'd1);
    chk("t1_busy1", {7'b0, bus.busy}, 8'd1);
    chk("t1_flags_busy", flags(), 8'd0);
    tick();
    chk("t1_done", {7'b0, bus.done}, 8'd1);
    chk("t1_flags", flags(), 8'b010);
    chk("t1_busy2", {7'b0, bus.busy}, 8'd0);
    tick();
    chk("t1_done_pulse", {7'b0, bus.done}, 8'd0);
    chk("t1_hold", flags(), 8'b010);
    // test 2: equal operands walk all four digits
    go(8'h5A, 8'h5A);
    chk("t2_sa3", {6'b0, bus.slice_A}, 8'd1);
    tick();
    chk("t2_sa2", {6'b0, bus.slice_A}, 8'd1);
    tick();
    chk("t2_sa1", {6'b0, bus.slice_A}, 8'd2);
    tick();
    chk("t2_sa0", {6'b0, bus.slice_A}, 8'd2);
    chk("t2_nodone", {7'b0, bus.done}, 8'd0);
    tick();
    chk("t2_done", {7'b0, bus.done}, 8'd1);
    chk("t2_flags", flags(), 8'b100);
    chk("t2_idle_slice", {6'b0, bus.slice_A}, 8'd0);
    tick();
    tick();
    chk("t2_hold", flags(), 8'b100);
    // test 3: difference only in the LSB digit
    go(8'h12, 8'h13);
    tick();
    tick();
    tick();
    chk("t3_nodone", {7'b0, bus.done}, 8'd0);
    tick();
    chk("t3_done", {7'b0, bus.done}, 8'd1);
    chk("t3_flags", flags(), 8'b001);
    tick();
    // test 4: start while busy ignored, back-to-back start in DONE accepted
    go(8'h5A, 8'h5A);
    tick();
    bus.A = 8'hFF;
    bus.B = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("t4_done", {7'b0, bus.done}, 8'd1);
    chk("t4_flags", flags(), 8'b100);
    go(8'h01, 8'h00);
    chk("t4_busy", {7'b0, bus.busy}, 8'd1);
    chk("t4_clear", flags(), 8'd0);
    tick();
    tick();
    tick();
    chk("t4b_nodone", {7'b0, bus.done}, 8'd0);
    tick();
    chk("t4b_done", {7'b0, bus.done}, 8'd1);
    chk("t4b_flags", flags(), 8'b010);
    tick();
    // test 5: reset aborts a compare
    go(8'h5A, 8'h5A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", {7'b0, bus.busy}, 8'd0);
    chk("t5_flags", flags(), 8'd0);
    chk("t5_slice", {6'b0, bus.slice_A}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_nodone", {7'b0, bus.done}, 8'd0);
    end
    // test 6: sign handling of the top digit
    go(8'h80, 8'h01);
    tick();
    chk("t6_done", {7'b0, bus.done}, 8'd1);
`ifdef CMP_SEQ_SIGNED_EN
    chk("t6_flags", flags(), 8'b001);
`else
    chk("t6_flags", flags(), 8'b010);
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
